float_classify_pipe: RTL and testbench
======================================

// Module: float_classify_pipe
// PURPOSE
//  Multi-lane, pipelined floating-point classifier for the EXU. Each beat carries LANES
//  operands. The block returns a one-hot class mask per lane, in RISC-V fclass encoding.
//  Uses valid/ready handshakes on both sides with full backpressure, throughput 1 beat/cycle.
//  Keeps sticky exception-summary flags and saturating event counters for the FCSR/perf logic.
// PARAMETERS
//  EXP    8   exponent width
//  FRAC   23  fraction width; operand width W = 1+EXP+FRAC
//  LANES  4   operands per beat (>=1)
//  CNT_W  16  width of each saturating event counter (>=2)
// PORTS
//  clk          in   1            clock
//  rst_n        in   1            async active-low reset
//  in_valid     in   1            input beat valid
//  in_ready     out  1            block can accept a beat
//  in_data      in   LANES*W      lane i = in_data[i*W +: W], as {sign,exponent,fraction}
//  in_lane_en   in   LANES        per-lane enable; a disabled lane is classified as "none"
//  out_valid    out  1            output beat valid
//  out_ready    in   1            downstream accepts the beat
//  out_class    out  LANES*10     lane i = out_class[i*10 +: 10], fclass one-hot or 0
//  out_lane_en  out  LANES        in_lane_en delayed with its beat
//  sticky_nan   out  1            a NaN (either kind) left the block since the last clear
//  sticky_snan  out  1            a signalling NaN left the block since the last clear
//  sticky_dnorm out  1            a subnormal left the block since the last clear
//  stat_clr     in   1            synchronous clear of sticky flags and counters
//  cnt_nan      out  CNT_W        saturating count of NaN lanes delivered
//  cnt_dnorm    out  CNT_W        saturating count of subnormal lanes delivered
// BEHAVIOUR
//  Reset: S1/S2 valids=0, out_valid=0, out_class=0, out_lane_en=0, all sticky flags=0, counters=0.
//   in_ready=1 once rst_n deasserts. Reset mid-beat discards all in-flight beats silently.
//  Pipeline, 2 register stages:
//   S1 captures sign, expZero, expMax, fracZero, quiet=frac[FRAC-1] and lane_en per lane.
//   S2 captures the 10-bit mask and is the output register.
//  Latency: beat accepted at cycle t appears on out_* at t+2 if out_ready stays high.
//  Handshake: a stage loads when it is empty or its downstream stage drains this cycle.
//   in_ready = !s1_v | (!s2_v | out_ready). Ready is combinational back-to-front; no bubbles.
//   in_data is registered only on in_valid & in_ready.
//   While out_valid=1 & out_ready=0, out_* hold stable and in_ready drops once S1 is also full.
//  Class bits: 0 -inf, 1 -norm, 2 -sub, 3 -0, 4 +0, 5 +sub, 6 +norm, 7 +inf, 8 sNaN, 9 qNaN.
//   NaN = expMax & !fracZero. It is quiet if the fraction MSB is 1. NaN ignores the sign.
//   Exactly one bit is set per enabled lane. A disabled lane gives 0.
//  Stats update only on an output transfer (out_valid & out_ready), counting enabled lanes only.
//   Per-beat increment = popcount across lanes, so it can reach LANES in one cycle.
//   Counters saturate at 2^CNT_W-1 and never wrap.
//  stat_clr together with a transfer: the clear applies first, then that beat's events.
//   Flags = this beat's events; counters = this beat's increment. No events are lost.
//  stat_clr does not affect the pipeline or the handshake.
// STRUCTURE
//  fpu_pkg gets:
//   typedef logic [9:0] fclass_t
//   localparams FCLASS_NEG_INF .. FCLASS_QNAN for the bit indices
//   function fclass_w(EXP,FRAC)
//  Sub-module fp_lane_classify: purely combinational.
//   Takes the S1 decode fields, returns fclass_t. Instantiated LANES times via generate.
//  Stats logic (flags plus two saturating adders) stays in the top module.
// TESTING
//  Single-lane values, LANES=4, all lanes enabled, out_ready=1, results 2 cycles after accept:
//   0x3F800000 -> 0x040; 0xFF800000 -> 0x001; 0x80000000 -> 0x008; 0x00000001 -> 0x020;
//   0x7FC00000 -> 0x200; 0x7F800001 -> 0x100.
//  Stats: lanes {0x7F800001, 0x7FC00000, 0x00000001, 0x3F800000}, lane_en=4'b0111
//   -> lane3 class 0; cnt_nan=2, cnt_dnorm=1; all three sticky flags 1.
//  Backpressure: stream 6 beats with out_ready=0 for 5 cycles
//   -> in_ready=0 after 2 beats accepted; out_* stable; after release all 6 beats in order.
//  Saturation: CNT_W=2, 2 beats of 4 qNaN lanes -> cnt_nan=3 and holds.
//   Then stat_clr with a beat carrying 1 NaN -> cnt_nan=1, sticky_nan=1.
//  Reset mid-flight: rst_n low with S1 and S2 full -> out_valid=0, counters 0 at once.
//   First beat after reset still arrives at t+2.
//  FP16 (EXP=5, FRAC=10): 0x7E00 -> 0x200; 0x7C01 -> 0x100; 0x8001 -> 0x004; 0xFC00 -> 0x001.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared floating-point classifier types: the fclass one-hot layout and operand width helper.
package fpu_pkg;

  typedef logic [9:0] fclass_t;

  localparam int unsigned FCLASS_NEG_INF  = 0;
  localparam int unsigned FCLASS_NEG_NORM = 1;
  localparam int unsigned FCLASS_NEG_SUB  = 2;
  localparam int unsigned FCLASS_NEG_ZERO = 3;
  localparam int unsigned FCLASS_POS_ZERO = 4;
  localparam int unsigned FCLASS_POS_SUB  = 5;
  localparam int unsigned FCLASS_POS_NORM = 6;
  localparam int unsigned FCLASS_POS_INF  = 7;
  localparam int unsigned FCLASS_SNAN     = 8;
  localparam int unsigned FCLASS_QNAN     = 9;

  function automatic int unsigned fclass_w(input int unsigned exp_w, input int unsigned frac_w);
    return 1 + exp_w + frac_w;
  endfunction

endpackage

// File: rtl/fp_lane_classify.sv
// Combinational fclass encoder for one lane, fed by the pre-decoded exponent/fraction fields.
module fp_lane_classify
  import fpu_pkg::*;
(
  input  logic    i_en,
  input  logic    i_sign,
  input  logic    i_exp_zero,
  input  logic    i_exp_max,
  input  logic    i_frac_zero,
  input  logic    i_quiet,
  output fclass_t o_class
);

  always_comb begin
    o_class = '0;
    if (i_en) begin
      // NaN classification ignores the sign bit.
      if (i_exp_max && !i_frac_zero) begin
        if (i_quiet) o_class[FCLASS_QNAN] = 1'b1;
        else         o_class[FCLASS_SNAN] = 1'b1;
      end else if (i_exp_max) begin
        if (i_sign) o_class[FCLASS_NEG_INF] = 1'b1;
        else        o_class[FCLASS_POS_INF] = 1'b1;
      end else if (i_exp_zero && i_frac_zero) begin
        if (i_sign) o_class[FCLASS_NEG_ZERO] = 1'b1;
        else        o_class[FCLASS_POS_ZERO] = 1'b1;
      end else if (i_exp_zero) begin
        if (i_sign) o_class[FCLASS_NEG_SUB] = 1'b1;
        else        o_class[FCLASS_POS_SUB] = 1'b1;
      end else begin
        if (i_sign) o_class[FCLASS_NEG_NORM] = 1'b1;
        else        o_class[FCLASS_POS_NORM] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/float_classify_pipe.sv
// Two-stage multi-lane fclass pipeline with valid/ready on both sides, sticky exception
// flags and saturating NaN/subnormal counters updated on each delivered beat.
module float_classify_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned EXP   = 8,
  parameter int unsigned FRAC  = 23,
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned W    = fclass_w(EXP, FRAC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*W-1:0]    in_data,
  input  logic [LANES-1:0]      in_lane_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*10-1:0]   out_class,
  output logic [LANES-1:0]      out_lane_en,
  output logic                  sticky_nan,
  output logic                  sticky_snan,
  output logic                  sticky_dnorm,
  input  logic                  stat_clr,
  output logic [CNT_W-1:0]      cnt_nan,
  output logic [CNT_W-1:0]      cnt_dnorm
);

  localparam int unsigned INC_W = $clog2(LANES + 1);
  localparam int unsigned SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

  // Handshake
  logic w_s2_load, w_s1_load, w_in_fire;
  logic r_s1_v, r_s2_v;

  assign w_s2_load = !r_s2_v || out_ready;
  assign w_s1_load = !r_s1_v || w_s2_load;
  assign w_in_fire = in_valid && w_s1_load;
  assign in_ready  = w_s1_load;

  // Field decode ahead of S1
  logic [LANES-1:0] w_sign, w_exp_zero, w_exp_max, w_frac_zero, w_quiet;

  always_comb begin
    w_sign      = '0;
    w_exp_zero  = '0;
    w_exp_max   = '0;
    w_frac_zero = '0;
    w_quiet     = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      w_sign[i]      = in_data[i*W + W - 1];
      w_exp_zero[i]  = (in_data[i*W + FRAC +: EXP] == '0);
      w_exp_max[i]   = &in_data[i*W + FRAC +: EXP];
      w_frac_zero[i] = (in_data[i*W +: FRAC] == '0);
      w_quiet[i]     = in_data[i*W + FRAC - 1];
    end
  end

  // Stage 1
  logic [LANES-1:0] r_s1_sign, r_s1_exp_zero, r_s1_exp_max, r_s1_frac_zero, r_s1_quiet;
  logic [LANES-1:0] r_s1_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v         <= 1'b0;
      r_s1_sign      <= '0;
      r_s1_exp_zero  <= '0;
      r_s1_exp_max   <= '0;
      r_s1_frac_zero <= '0;
      r_s1_quiet     <= '0;
      r_s1_en        <= '0;
    end else begin
      if (w_s1_load) r_s1_v <= in_valid;
      if (w_in_fire) begin
        r_s1_sign      <= w_sign;
        r_s1_exp_zero  <= w_exp_zero;
        r_s1_exp_max   <= w_exp_max;
        r_s1_frac_zero <= w_frac_zero;
        r_s1_quiet     <= w_quiet;
        r_s1_en        <= in_lane_en;
      end
    end
  end

  // Per-lane classification between S1 and S2
  logic [LANES*10-1:0] w_class;

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    fp_lane_classify u_cls (
      .i_en        (r_s1_en[g]),
      .i_sign      (r_s1_sign[g]),
      .i_exp_zero  (r_s1_exp_zero[g]),
      .i_exp_max   (r_s1_exp_max[g]),
      .i_frac_zero (r_s1_frac_zero[g]),
      .i_quiet     (r_s1_quiet[g]),
      .o_class     (w_class[g*10 +: 10])
    );
  end

  // Stage 2 / output register
  logic [LANES*10-1:0] r_s2_class;
  logic [LANES-1:0]    r_s2_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v     <= 1'b0;
      r_s2_class <= '0;
      r_s2_en    <= '0;
    end else if (w_s2_load) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_class <= w_class;
        r_s2_en    <= r_s1_en;
      end
    end
  end

  assign out_valid   = r_s2_v;
  assign out_class   = r_s2_class;
  assign out_lane_en = r_s2_en;

  // Event statistics on delivered beats
  logic             w_xfer;
  logic             w_any_nan, w_any_snan, w_any_dnorm;
  logic [INC_W-1:0] w_nan_inc, w_dnorm_inc;

  assign w_xfer = r_s2_v && out_ready;

  // Disabled lanes carry an all-zero class, so they never contribute events.
  always_comb begin
    w_nan_inc   = '0;
    w_dnorm_inc = '0;
    w_any_nan   = 1'b0;
    w_any_snan  = 1'b0;
    w_any_dnorm = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      w_nan_inc   = w_nan_inc + INC_W'(r_s2_class[i*10 + FCLASS_SNAN] |
                                       r_s2_class[i*10 + FCLASS_QNAN]);
      w_dnorm_inc = w_dnorm_inc + INC_W'(r_s2_class[i*10 + FCLASS_NEG_SUB] |
                                         r_s2_class[i*10 + FCLASS_POS_SUB]);
    end
    w_any_nan   = (w_nan_inc != '0);
    w_any_dnorm = (w_dnorm_inc != '0);
    for (int i = 0; i < int'(LANES); i++) begin
      w_any_snan = w_any_snan | r_s2_class[i*10 + FCLASS_SNAN];
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [INC_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return (s > CNT_MAX) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic             r_sticky_nan, r_sticky_snan, r_sticky_dnorm;
  logic             w_sticky_nan_d, w_sticky_snan_d, w_sticky_dnorm_d;
  logic [CNT_W-1:0] r_cnt_nan, r_cnt_dnorm;
  logic [CNT_W-1:0] w_cnt_nan_d, w_cnt_dnorm_d;

  // A clear coinciding with a transfer wipes history first, then records that beat.
  always_comb begin
    w_sticky_nan_d   = (r_sticky_nan && !stat_clr) || (w_xfer && w_any_nan);
    w_sticky_snan_d  = (r_sticky_snan && !stat_clr) || (w_xfer && w_any_snan);
    w_sticky_dnorm_d = (r_sticky_dnorm && !stat_clr) || (w_xfer && w_any_dnorm);
    w_cnt_nan_d      = stat_clr ? '0 : r_cnt_nan;
    w_cnt_dnorm_d    = stat_clr ? '0 : r_cnt_dnorm;
    if (w_xfer) begin
      w_cnt_nan_d   = sat_add(w_cnt_nan_d, w_nan_inc);
      w_cnt_dnorm_d = sat_add(w_cnt_dnorm_d, w_dnorm_inc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_nan   <= 1'b0;
      r_sticky_snan  <= 1'b0;
      r_sticky_dnorm <= 1'b0;
      r_cnt_nan      <= '0;
      r_cnt_dnorm    <= '0;
    end else begin
      r_sticky_nan   <= w_sticky_nan_d;
      r_sticky_snan  <= w_sticky_snan_d;
      r_sticky_dnorm <= w_sticky_dnorm_d;
      r_cnt_nan      <= w_cnt_nan_d;
      r_cnt_dnorm    <= w_cnt_dnorm_d;
    end
  end

  assign sticky_nan   = r_sticky_nan;
  assign sticky_snan  = r_sticky_snan;
  assign sticky_dnorm = r_sticky_dnorm;
  assign cnt_nan      = r_cnt_nan;
  assign cnt_dnorm    = r_cnt_dnorm;

endmodule

// File: tb/tb_float_classify_pipe.sv
// Bench for float_classify_pipe: FP32 main instance checked every cycle against a queue model,
// plus a CNT_W=2 instance for saturation and an FP16 instance for narrow formats.
module tb_float_classify_pipe;

  localparam int LANES = 4;
  localparam int W     = 32;
  localparam int EW    = LANES * 10 + LANES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Main FP32 instance
  logic                  in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, stat_clr = 1'b0;
  logic [LANES*W-1:0]    in_data = '0;
  logic [LANES-1:0]      in_lane_en = '0, out_lane_en;
  logic [LANES*10-1:0]   out_class;
  logic                  sticky_nan, sticky_snan, sticky_dnorm;
  logic [15:0]           cnt_nan, cnt_dnorm;

  float_classify_pipe #(.EXP(8), .FRAC(23), .LANES(LANES), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_lane_en(in_lane_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_lane_en(out_lane_en), .sticky_nan(sticky_nan),
    .sticky_snan(sticky_snan), .sticky_dnorm(sticky_dnorm), .stat_clr(stat_clr),
    .cnt_nan(cnt_nan), .cnt_dnorm(cnt_dnorm)
  );

  // Saturation instance
  logic                  s_in_valid = 1'b0, s_in_ready, s_out_valid, s_stat_clr = 1'b0;
  logic [LANES*W-1:0]    s_in_data = '0;
  logic [LANES-1:0]      s_out_lane_en;
  logic [LANES*10-1:0]   s_out_class;
  logic                  s_sticky_nan, s_sticky_snan, s_sticky_dnorm;
  logic [1:0]            s_cnt_nan, s_cnt_dnorm;

  float_classify_pipe #(.EXP(8), .FRAC(23), .LANES(LANES), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_lane_en(4'hF), .out_valid(s_out_valid), .out_ready(1'b1),
    .out_class(s_out_class), .out_lane_en(s_out_lane_en), .sticky_nan(s_sticky_nan),
    .sticky_snan(s_sticky_snan), .sticky_dnorm(s_sticky_dnorm), .stat_clr(s_stat_clr),
    .cnt_nan(s_cnt_nan), .cnt_dnorm(s_cnt_dnorm)
  );

  // FP16 instance
  logic                  h_in_valid = 1'b0, h_in_ready, h_out_valid;
  logic [LANES*16-1:0]   h_in_data = '0;
  logic [LANES-1:0]      h_out_lane_en;
  logic [LANES*10-1:0]   h_out_class;
  logic                  h_sticky_nan, h_sticky_snan, h_sticky_dnorm;
  logic [15:0]           h_cnt_nan, h_cnt_dnorm;

  float_classify_pipe #(.EXP(5), .FRAC(10), .LANES(LANES), .CNT_W(16)) u_h16 (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_data(h_in_data), .in_lane_en(4'hF), .out_valid(h_out_valid), .out_ready(1'b1),
    .out_class(h_out_class), .out_lane_en(h_out_lane_en), .sticky_nan(h_sticky_nan),
    .sticky_snan(h_sticky_snan), .sticky_dnorm(h_sticky_dnorm), .stat_clr(1'b0),
    .cnt_nan(h_cnt_nan), .cnt_dnorm(h_cnt_dnorm)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference classification straight from the IEEE field rules.
  function automatic logic [9:0] model_class(input logic [31:0] bits, input int e, input int f,
                                             input logic en);
    logic [31:0] fr, ex;
    logic        s;
    int          idx;
    logic [9:0]  one;
    one = 10'd1;
    if (!en) return '0;
    fr = bits & ((32'd1 << f) - 32'd1);
    ex = (bits >> f) & ((32'd1 << e) - 32'd1);
    s  = bits[e+f];
    if (ex == (32'd1 << e) - 32'd1) begin
      if (fr == 0) idx = s ? 0 : 7;
      else         idx = ((fr >> (f - 1)) != 0) ? 9 : 8;
    end else if (ex == 0) begin
      if (fr == 0) idx = s ? 3 : 4;
      else         idx = s ? 2 : 5;
    end else begin
      idx = s ? 1 : 6;
    end
    return one << idx;
  endfunction

  function automatic logic [EW-1:0] model_beat(input logic [LANES*W-1:0] d,
                                               input logic [LANES-1:0] en);
    logic [EW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*10 +: 10] = model_class(d[i*W +: W], 8, 23, en[i]);
    r[LANES*10 +: LANES] = en;
    return r;
  endfunction

  // Per-cycle scoreboard for the main instance
  logic [EW-1:0]       exp_q[$];
  int                  m_nan = 0, m_dn = 0;
  logic                m_sn = 0, m_ss = 0, m_sd = 0;
  logic                prev_stall = 0;
  logic [LANES*10-1:0] prev_class = '0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic          xfer;
    if (!rst_n) begin
      exp_q.delete();
      m_nan = 0; m_dn = 0; m_sn = 0; m_ss = 0; m_sd = 0;
      prev_stall = 0;
    end else begin
      chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
      chk("cnt_nan", cnt_nan, m_nan);
      chk("cnt_dnorm", cnt_dnorm, m_dn);
      chk("sticky_nan", sticky_nan, m_sn);
      chk("sticky_snan", sticky_snan, m_ss);
      chk("sticky_dnorm", sticky_dnorm, m_sd);
      if (prev_stall) chk("stall_hold", out_class, prev_class);
      xfer = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out", out_valid, 1'b0);
        else begin
          e = exp_q[0];
          chk("out_class", out_class, e[LANES*10-1:0]);
          chk("out_lane_en", out_lane_en, e[LANES*10 +: LANES]);
          xfer = out_ready;
        end
      end
      if (stat_clr) begin
        m_nan = 0; m_dn = 0; m_sn = 0; m_ss = 0; m_sd = 0;
      end
      if (xfer) begin
        for (int i = 0; i < LANES; i++) begin
          if (e[i*10+8] || e[i*10+9]) begin m_nan++; m_sn = 1; end
          if (e[i*10+8]) m_ss = 1;
          if (e[i*10+2] || e[i*10+5]) begin m_dn++; m_sd = 1; end
        end
        if (m_nan > 65535) m_nan = 65535;
        if (m_dn > 65535) m_dn = 65535;
        void'(exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_class = out_class;
      if (in_valid && in_ready) exp_q.push_back(model_beat(in_data, in_lane_en));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [LANES*W-1:0] d, input logic [LANES-1:0] en);
    logic acc;
    acc = 1'b0;
    in_data = d; in_lane_en = en; in_valid = 1'b1;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", acc, 1'b1);
  endtask

  logic [31:0] tbl[8] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 32'h00000001,
                          32'h7FC00000, 32'h7F800001, 32'h807FFFFF, 32'h7F800000};

  function automatic logic [LANES*W-1:0] mk(input int k);
    logic [LANES*W-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*W +: W] = tbl[(k + i) % 8];
    return d;
  endfunction

  logic [31:0] dv[6]  = '{32'h3F800000, 32'hFF800000, 32'h80000000, 32'h00000001,
                          32'h7FC00000, 32'h7F800001};
  logic [9:0]  dexp[6] = '{10'h040, 10'h001, 10'h008, 10'h020, 10'h200, 10'h100};

  initial begin
    logic [LANES*10-1:0] snap;
    logic                acc;
    int                  k, cyc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_class", out_class, '0);
    chk("rst_out_lane_en", out_lane_en, '0);
    chk("rst_flags", {sticky_nan, sticky_snan, sticky_dnorm}, 3'b000);
    chk("rst_cnts", {cnt_nan, cnt_dnorm}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    tick();

    // Single values, result 2 cycles after accept
    for (int j = 0; j < 6; j++) begin
      send({LANES{dv[j]}}, 4'hF);
      tick();
      chk("single_valid", out_valid, 1'b1);
      chk("single_lane0", out_class[9:0], dexp[j]);
      chk("single_lane3", out_class[39:30], dexp[j]);
    end
    repeat (3) tick();

    // Stats beat after a standalone clear
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    chk("clr_cnt_nan", cnt_nan, 16'd0);
    send({32'h3F800000, 32'h00000001, 32'h7FC00000, 32'h7F800001}, 4'b0111);
    tick();
    chk("stat_lane3", out_class[39:30], 10'h000);
    chk("stat_lane2", out_class[29:20], 10'h020);
    chk("stat_lane1", out_class[19:10], 10'h200);
    chk("stat_lane0", out_class[9:0], 10'h100);
    tick();
    chk("stat_cnt_nan", cnt_nan, 16'd2);
    chk("stat_cnt_dnorm", cnt_dnorm, 16'd1);
    chk("stat_flags", {sticky_nan, sticky_snan, sticky_dnorm}, 3'b111);

    // Backpressure: out_ready low for five cycles while streaming six beats
    k = 0; cyc = 0; snap = '0;
    while (k < 6 && cyc < 200) begin
      out_ready = (cyc >= 5);
      in_valid = 1'b1; in_data = mk(k); in_lane_en = 4'(15 - k);
      @(negedge clk);
      acc = in_ready;
      if (cyc == 2) snap = out_class;
      if (cyc == 4) begin
        chk("bp_accepted", k, 2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_out_stable", out_class, snap);
      end
      tick();
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_all_sent", k, 6);
    for (int c = 0; c < 30 && (exp_q.size() != 0 || out_valid); c++) tick();
    chk("bp_drained", exp_q.size(), 0);

    // Reset with both stages full
    out_ready = 1'b0;
    send(mk(1), 4'hF);
    send(mk(2), 4'hF);
    chk("mid_out_valid_pre", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 1'b0);
    chk("mid_cnts", {cnt_nan, cnt_dnorm}, 32'd0);
    chk("mid_flags", {sticky_nan, sticky_snan, sticky_dnorm}, 3'b000);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    send({LANES{32'h7F800001}}, 4'hF);
    chk("post_rst_t1", out_valid, 1'b0);
    tick();
    chk("post_rst_t2", out_valid, 1'b1);
    chk("post_rst_class", out_class[9:0], 10'h100);
    repeat (3) tick();

    // Saturation with CNT_W=2
    s_in_data = {LANES{32'h7FC00000}}; s_in_valid = 1'b1;
    @(negedge clk);
    chk("sat_in_ready", s_in_ready, 1'b1);
    tick(); tick();
    s_in_valid = 1'b0;
    tick();
    chk("sat_cnt_first", s_cnt_nan, 2'd3);
    tick(); tick(); tick();
    chk("sat_cnt_hold", s_cnt_nan, 2'd3);
    chk("sat_sticky", s_sticky_nan, 1'b1);
    s_in_data = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7FC00000}; s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    tick();
    chk("sat_clr_valid", s_out_valid, 1'b1);
    s_stat_clr = 1'b1;
    tick();
    s_stat_clr = 1'b0;
    chk("sat_clr_cnt", s_cnt_nan, 2'd1);
    chk("sat_clr_sticky", {s_sticky_nan, s_sticky_snan, s_sticky_dnorm}, 3'b100);

    // FP16 format
    h_in_data = {16'hFC00, 16'h8001, 16'h7C01, 16'h7E00}; h_in_valid = 1'b1;
    tick();
    h_in_valid = 1'b0;
    tick();
    chk("h16_valid", h_out_valid, 1'b1);
    chk("h16_lane0", h_out_class[9:0], 10'h200);
    chk("h16_lane1", h_out_class[19:10], 10'h100);
    chk("h16_lane2", h_out_class[29:20], 10'h004);
    chk("h16_lane3", h_out_class[39:30], 10'h001);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
